// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int INSN_W    = 16;
    localparam int BYTE_W    = 8;
    localparam int MAX_WORDS = 256;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LO,
        HI,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    // States in which the loader is waiting for a stream byte.
    function automatic logic is_rx_state(input state_t s);
        return (s == LEN) || (s == LO) || (s == HI) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_gap_timer.sv
// Idle-gap watchdog: counts cycles without a transfer and flags expiry.
module gap_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LIMIT =
        CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [CNT_W-1:0] count;

    // Count idle cycles; saturate at the limit, a zero timeout keeps the counter parked.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if ((TIMEOUT_CYC > 0) && run && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT_CYC > 0) && (count == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Streams length-prefixed, XOR-checksummed byte pairs into instruction memory
// and keeps the CPU in reset until a load verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int BASE_ADDR     = 0,
    parameter int TIMEOUT_CYC   = 1024,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [INSN_W-1:0] imem_wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [8:0]        words_loaded
);

    localparam int IDX_W = $clog2(MAX_WORDS);

    state_t             state;
    state_t             state_nxt;
    logic [BYTE_W-1:0]  lo_byte;
    logic [BYTE_W-1:0]  csum;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   last_idx;
    logic               xfer;
    logic               start_ok;
    logic               expired;
    logic               timeout;

    assign rx_ready   = is_rx_state(state);
    assign imem_wr_en = (state == WRITE);
    assign busy       = (state != IDLE) && (state != DONE) && (state != ERR);
    assign xfer       = rx_valid && rx_ready;
    assign start_ok   = start && !busy;
    // A transfer in the expiry cycle wins over the timeout.
    assign timeout    = expired && is_rx_state(state) && !xfer;

    gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (xfer || start_ok),
        .run    (is_rx_state(state) && !xfer),
        .expired(expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = LEN;
            LEN: begin
                if (timeout)   state_nxt = ERR;
                else if (xfer) state_nxt = LO;
            end
            LO: begin
                if (timeout)   state_nxt = ERR;
                else if (xfer) state_nxt = HI;
            end
            HI: begin
                if (timeout)   state_nxt = ERR;
                else if (xfer) state_nxt = WRITE;
            end
            WRITE: state_nxt = (idx == last_idx) ? CSUM : LO;
            CSUM: begin
                if (timeout)   state_nxt = ERR;
                else if (xfer) state_nxt = (rx_data == csum) ? DONE : ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, checksum, counters and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_hold     <= HOLD_AT_RESET;
            done         <= 1'b0;
            err          <= 1'b0;
            csum         <= '0;
            idx          <= '0;
            last_idx     <= '0;
            lo_byte      <= '0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        csum         <= '0;
                        idx          <= '0;
                        words_loaded <= '0;
                    end
                end
                LEN: begin
                    if (xfer) begin
                        // L==0 encodes 256 words; the 8-bit wrap of L-1 gives 255.
                        last_idx <= rx_data - 8'd1;
                        csum     <= csum ^ rx_data;
                    end
                    if (timeout) err <= 1'b1;
                end
                LO: begin
                    if (xfer) begin
                        lo_byte <= rx_data;
                        csum    <= csum ^ rx_data;
                    end
                    if (timeout) err <= 1'b1;
                end
                HI: begin
                    if (xfer) begin
                        imem_wr_data <= {rx_data, lo_byte};
                        imem_wr_addr <= ADDR_W'(BASE_ADDR + int'(idx));
                        csum         <= csum ^ rx_data;
                    end
                    if (timeout) err <= 1'b1;
                end
                WRITE: begin
                    idx          <= idx + 1'b1;
                    words_loaded <= words_loaded + 9'd1;
                end
                CSUM: begin
                    if (xfer) begin
                        if (rx_data == csum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    if (timeout) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
